multi_rate_tick_gen: RTL and testbench

- Bank of NUM_CH independent, run-time-programmable clock dividers driven from the 50 MHz board clock.
- Generalises the fixed 0.5 Hz divider. Each channel has its own divisor, a selectable output mode (50% square wave or single-cycle tick), an enable, and glitch-free divisor reload.
- Feeds layer-scan, animation-step and brightness-PWM timing in the LED cube from a single block.

---
 rtl/multi_rate_tick_gen.sv | 161 ++++++++++++++++
 tb/tb_multi_rate_tick_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rate_tick_gen.sv
// ---------------------------------------------------------------------------
// multi_rate_tick_gen
//
// A bank of NUM_CH independent clock dividers running from the 50 MHz board
// clock. Each channel has its own divisor, its own output mode and its own
// enable. A new divisor/mode is written into a per-channel shadow register
// and applied without glitches at the channel's next terminal count, or on
// the next edge if the channel is stopped.
//
// Ports:
//   clk_50MHz    in   1       system clock
//   reset        in   1       asynchronous, active-high reset
//   run_en       in   NUM_CH  per-channel count enable
//   sync_restart in   1       synchronous restart of all channels
//   cfg_valid    in   1       configuration write request
//   cfg_ready    out  1       configuration write can be accepted
//   cfg_ch       in   CH_W    target channel of the write
//   cfg_div      in   CNT_W   new divisor (0 is treated as 1)
//   cfg_mode     in   1       new mode (0 = toggle, 1 = pulse)
//   cfg_pending  out  NUM_CH  shadow holds a configuration not yet applied
//   tick_out     out  NUM_CH  one-cycle pulse after each terminal count
//   clk_out      out  NUM_CH  divided output (square wave or pulse)
//
// Configuration handshake: a write is accepted on a rising clk_50MHz edge
// where cfg_valid and cfg_ready are both high. cfg_ready is combinational
// from cfg_ch and the pending flags; it is low only while the addressed
// channel still holds an unapplied shadow. Writes to a channel number at or
// above NUM_CH are always "ready" and are dropped. cfg_valid may be held
// high; each edge with cfg_ready high is a separate accept.
// ---------------------------------------------------------------------------
module multi_rate_tick_gen #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 27,
    parameter int DEFAULT_DIV  = 25000000,
    parameter int DEFAULT_MODE = 0,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] run_en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic             MODE_RST = (DEFAULT_MODE != 0);

    // A zero divisor would never reach terminal count; treat it as 1.
    logic [CNT_W-1:0] cfg_div_clamped;
    assign cfg_div_clamped = (cfg_div == '0) ? CNT_W'(1) : cfg_div;

    // Out-of-range channel numbers match no channel and stay ready.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~cfg_pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic             mode;
        logic [CNT_W-1:0] sh_div;
        logic             sh_mode;
        logic             pend;
        logic             tick;
        logic             clk_q;

        logic accept;
        logic tc;
        logic apply_now;
        logic next_mode;
        logic mode_chg;

        assign accept    = cfg_valid & ~pend & (cfg_ch == CH_W'(g));
        assign tc        = run_en[g] & (cnt == div - CNT_W'(1));
        // Outside a restart a shadow goes live either at the wrap edge of a
        // running channel or on the first edge of a stopped one. accept is
        // gated by ~pend, so accept and apply never coincide.
        assign apply_now = pend & (~run_en[g] | tc);
        assign next_mode = apply_now ? sh_mode : mode;
        assign mode_chg  = apply_now & (sh_mode != mode);

        always_ff @(posedge clk_50MHz or posedge reset) begin
            if (reset) begin
                cnt     <= '0;
                div     <= DIV_RST;
                mode    <= MODE_RST;
                sh_div  <= DIV_RST;
                sh_mode <= MODE_RST;
                pend    <= 1'b0;
                tick    <= 1'b0;
                clk_q   <= 1'b0;
            end else if (sync_restart) begin
                cnt   <= '0;
                tick  <= 1'b0;
                clk_q <= 1'b0;
                pend  <= 1'b0;
                // A write in the restart cycle bypasses the shadow.
                if (accept) begin
                    div  <= cfg_div_clamped;
                    mode <= cfg_mode;
                end else if (pend) begin
                    div  <= sh_div;
                    mode <= sh_mode;
                end
            end else begin
                if (accept) begin
                    sh_div  <= cfg_div_clamped;
                    sh_mode <= cfg_mode;
                    pend    <= 1'b1;
                end else if (apply_now) begin
                    div  <= sh_div;
                    mode <= sh_mode;
                    pend <= 1'b0;
                end

                if (!run_en[g]) begin
                    cnt  <= '0;
                    tick <= 1'b0;
                    // Toggle output freezes while stopped unless the mode
                    // is being switched; pulse output follows tick (0).
                    if (next_mode || mode_chg) begin
                        clk_q <= 1'b0;
                    end
                end else if (tc) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    if (next_mode) begin
                        clk_q <= 1'b1;
                    end else if (mode_chg) begin
                        clk_q <= 1'b0;
                    end else begin
                        clk_q <= ~clk_q;
                    end
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    tick <= 1'b0;
                    if (next_mode) begin
                        clk_q <= 1'b0;
                    end
                end
            end
        end

        assign cfg_pending[g] = pend;
        assign tick_out[g]    = tick;
        assign clk_out[g]     = clk_q;
    end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_rate_tick_gen
//
// Directed then randomized stimulus for multi_rate_tick_gen with three
// channels, 8-bit counters and a default divisor of 4. The reference model
// tracks, per channel, how many enabled edges remain until the next
// terminal count, and derives tick/clk/pending from that.
// ---------------------------------------------------------------------------
module tb_multi_rate_tick_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;
    localparam int DDIV   = 4;
    localparam int DMODE  = 0;
    localparam int CH_W   = 2;

    logic              clk_50MHz;
    logic              reset;
    logic [NUM_CH-1:0] run_en;
    logic              sync_restart;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] cfg_pending;
    logic [NUM_CH-1:0] tick_out;
    logic [NUM_CH-1:0] clk_out;

    multi_rate_tick_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DDIV),
        .DEFAULT_MODE(DMODE),
        .CH_W        (CH_W)
    ) dut (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .run_en      (run_en),
        .sync_restart(sync_restart),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_mode    (cfg_mode),
        .cfg_pending (cfg_pending),
        .tick_out    (tick_out),
        .clk_out     (clk_out)
    );

    // ---------------- clock ----------------
    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    // ---------------- reference model ----------------
    int m_left [NUM_CH];   // enabled edges until next terminal count
    int m_div  [NUM_CH];
    int m_sdiv [NUM_CH];
    bit m_mode [NUM_CH];
    bit m_smode[NUM_CH];
    bit m_pend [NUM_CH];
    bit m_tick [NUM_CH];
    bit m_clk  [NUM_CH];

    int n_cmp;
    int n_err;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]   = DDIV;
            m_sdiv[i]  = DDIV;
            m_mode[i]  = (DMODE != 0);
            m_smode[i] = (DMODE != 0);
            m_left[i]  = DDIV;
            m_pend[i]  = 1'b0;
            m_tick[i]  = 1'b0;
            m_clk[i]   = 1'b0;
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    // Advances the model by one rising edge using the inputs that were
    // stable before that edge.
    task automatic model_edge();
        bit acc, tc, applied, old_mode;
        int cdiv;
        if (reset) begin
            model_reset();
            return;
        end
        cdiv = (cfg_div == 0) ? 1 : int'(cfg_div);
        for (int i = 0; i < NUM_CH; i++) begin
            acc      = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
            old_mode = m_mode[i];
            applied  = 1'b0;
            tc       = 1'b0;
            if (sync_restart) begin
                if (acc) begin
                    m_div[i]  = cdiv;
                    m_mode[i] = cfg_mode;
                end else if (m_pend[i]) begin
                    m_div[i]  = m_sdiv[i];
                    m_mode[i] = m_smode[i];
                end
                m_pend[i] = 1'b0;
                m_left[i] = m_div[i];
                m_tick[i] = 1'b0;
                m_clk[i]  = 1'b0;
            end else begin
                if (run_en[i]) begin
                    m_left[i] = m_left[i] - 1;
                    tc = (m_left[i] == 0);
                end
                if (m_pend[i] && (!run_en[i] || tc)) begin
                    m_div[i]  = m_sdiv[i];
                    m_mode[i] = m_smode[i];
                    m_pend[i] = 1'b0;
                    applied   = 1'b1;
                end
                if (!run_en[i] || tc) m_left[i] = m_div[i];
                m_tick[i] = tc;
                if (m_mode[i])                            m_clk[i] = m_tick[i];
                else if (applied && old_mode != m_mode[i]) m_clk[i] = 1'b0;
                else if (tc)                              m_clk[i] = !m_clk[i];
                if (acc) begin
                    m_sdiv[i]  = cdiv;
                    m_smode[i] = cfg_mode;
                    m_pend[i]  = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [NUM_CH-1:0] pack(input bit v[NUM_CH]);
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = v[i];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".tick"},    32'(tick_out),    32'(pack(m_tick)));
        check({tag, ".clk"},     32'(clk_out),     32'(pack(m_clk)));
        check({tag, ".pending"}, 32'(cfg_pending), 32'(pack(m_pend)));
    endtask

    // ---------------- driver tasks ----------------
    // One clock: check the combinational ready mid-cycle, then the
    // registered outputs just after the edge.
    task automatic step(input string tag);
        @(negedge clk_50MHz);
        check({tag, ".ready"}, 32'(cfg_ready), 32'(model_ready()));
        @(posedge clk_50MHz);
        #1;
        model_edge();
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    task automatic cfg_write(input int ch, input int dv, input bit md, input string tag);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        cfg_mode  = md;
        step(tag);
        cfg_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        reset        = 1'b1;
        run_en       = '0;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_div      = '0;
        cfg_mode     = 1'b0;

        // Reset state.
        run(2, "reset");
        reset = 1'b0;

        // Default divisor 4, toggle mode, two channels phase-aligned.
        run_en = 3'b011;
        run(22, "default");

        // Reload ch0 mid-period, then a second write while it is pending.
        run(1, "pre_reload");
        cfg_write(0, 2, 1'b0, "reload");
        cfg_write(0, 3, 1'b0, "reload_busy");
        run(10, "reload_run");

        // div 0 clamps to 1, pulse mode: continuously high once applied.
        cfg_write(1, 0, 1'b1, "div0_pulse");
        run(12, "div1_run");

        // Out-of-range channel: always ready, write discarded.
        cfg_write(3, 5, 1'b1, "bad_ch");
        run(2, "bad_ch_run");

        // Disable ch0 for 10 cycles, configure it while stopped, re-enable.
        run_en = 3'b010;
        run(2, "disable");
        cfg_write(0, 3, 1'b0, "cfg_stopped");
        run(7, "disable_hold");
        run_en = 3'b011;
        run(12, "reenable");

        // Restart with ch0 pending and a simultaneous write to ch1.
        cfg_write(0, 5, 1'b0, "pend_ch0");
        sync_restart = 1'b1;
        cfg_write(1, 3, 1'b0, "restart");
        sync_restart = 1'b0;
        run(20, "after_restart");

        // Randomized phase.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) run_en = NUM_CH'($urandom_range(0, 7));
            sync_restart = ($urandom_range(0, 24) == 0);
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_ch       = CH_W'($urandom_range(0, 3));
            cfg_div      = CNT_W'($urandom_range(0, 6));
            cfg_mode     = 1'($urandom_range(0, 1));
            step("random");
        end
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;

        // Asynchronous reset between edges.
        run_en = 3'b111;
        cfg_write(2, 6, 1'b1, "pre_async");
        run(3, "pre_async_run");
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        run(1, "async_hold");
        reset = 1'b0;
        run(20, "post_async");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
